// File: rtl/ifetch_r32i.sv
// rtl/ifetch_r32i.sv - RV32I instruction fetch unit with instruction FIFO
//
// Fetches one word per accepted program address over a req/ack memory
// handshake and buffers the results for the decoder.
//   clock, reset        rising-edge clock, async active-high reset
//   ProgAddr, PCStall   address from the PC; PCStall tells the PC to hold
//   Flush               taken branch: drop buffered and in-flight fetches
//   MemReq/MemAddr      read request to instruction memory
//   MemAck/MemRData     memory response, data valid with ack
//   InstrValid/Instr/InstrAddr/InstrReady  decoder handshake, FIFO head
//   FetchFault          sticky misaligned-fetch flag
module ifetch_r32i #(
  parameter int dataW = 32,
  parameter int Depth = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [dataW-1:0] ProgAddr,
  input  logic             Flush,
  output logic             PCStall,
  output logic             MemReq,
  output logic [dataW-1:0] MemAddr,
  input  logic             MemAck,
  input  logic [dataW-1:0] MemRData,
  output logic             InstrValid,
  output logic [dataW-1:0] Instr,
  output logic [dataW-1:0] InstrAddr,
  input  logic             InstrReady,
  output logic             FetchFault
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthC = CntW'(Depth);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;
  localparam logic [1:0] FAULT   = 2'd3;

  logic [1:0]       state;
  logic [CntW-1:0]  count;
  logic [PtrW-1:0]  rd_ptr;
  logic [PtrW-1:0]  wr_ptr;
  logic [dataW-1:0] fifo_data [Depth];
  logic [dataW-1:0] fifo_addr [Depth];
  logic             accept;
  logic             push;
  logic             pop;

  // Acceptance looks only at registered occupancy, so a slot is always
  // reserved for the single outstanding request when its ack arrives.
  assign accept     = (state == IDLE) && (count < DepthC) && !Flush;
  assign PCStall    = !accept;
  assign push       = (state == REQ) && MemAck && !Flush;
  assign pop        = (count != '0) && InstrReady && !Flush;
  assign InstrValid = (count != '0);
  assign Instr      = fifo_data[rd_ptr];
  assign InstrAddr  = fifo_addr[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      MemReq     <= 1'b0;
      MemAddr    <= '0;
      FetchFault <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (ProgAddr[1:0] == 2'b00) begin
              MemAddr <= ProgAddr;
              MemReq  <= 1'b1;
              state   <= REQ;
            end else begin
              FetchFault <= 1'b1;
              state      <= FAULT;
            end
          end
        end
        REQ: begin
          // A request cannot be withdrawn; a flush before the ack leaves
          // it running in DISCARD so its data can be thrown away.
          if (MemAck) begin
            MemReq <= 1'b0;
            state  <= IDLE;
          end else if (Flush) begin
            state <= DISCARD;
          end
        end
        DISCARD: begin
          if (MemAck) begin
            MemReq <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          MemReq <= 1'b0;
          state  <= FAULT;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < Depth; i++) begin
        fifo_data[i] <= '0;
        fifo_addr[i] <= '0;
      end
    end else if (Flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= MemRData;
        fifo_addr[wr_ptr] <= MemAddr;
        wr_ptr            <= wr_ptr + PtrW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/ifetch_r32i.md
Name: ifetch_r32i

Overview:
Instruction fetch unit for the RISCV32I core. It sits between the program counter and instruction memory. It consumes the PC's ProgAddr, issues word reads to instruction memory over a req/ack handshake, and buffers the returned instructions in a small FIFO. It presents instructions to the decoder with a valid/ready handshake and stalls the PC while it cannot accept a new address. On a taken branch it flushes all buffered and in-flight instructions.

Parameters:
dataW, 32, width of addresses and instruction words
Depth, 2, instruction FIFO entries (power of two, >=2)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
ProgAddr  input  dataW  current program address from PC
Flush  input  1  one-cycle pulse: branch taken, discard all fetched/in-flight instructions
PCStall  output  1  high when ProgAddr is not accepted this cycle; PC must hold its value
MemReq  output  1  instruction memory read request
MemAddr  output  dataW  read address, stable while MemReq high
MemAck  input  1  memory response valid; MemRData valid in same cycle
MemRData  input  dataW  instruction word returned by memory
InstrValid  output  1  FIFO head holds a valid instruction
Instr  output  dataW  instruction at FIFO head
InstrAddr  output  dataW  address of Instr
InstrReady  input  1  decoder accepts Instr this cycle
FetchFault  output  1  sticky: misaligned fetch address detected

Behaviour:
- Reset (async, any state): state=IDLE, MemReq=0, MemAddr=0, FIFO empty, InstrValid=0, Instr=0, InstrAddr=0, FetchFault=0. PCStall follows its equation with state IDLE and count 0, so it is 0 during reset unless Flush is high.
- State machine: IDLE, REQ, DISCARD, FAULT.
- Accept = (state==IDLE) && (count<Depth) && !Flush. count is the registered FIFO occupancy; a same-cycle pop does not free a slot for acceptance.
- PCStall = !Accept, combinational from registered state/count and Flush.
- IDLE, Accept, ProgAddr[1:0]==0: MemAddr<=ProgAddr, MemReq<=1, go to REQ.
- IDLE, Accept, ProgAddr[1:0]!=0: FetchFault<=1, go to FAULT. No memory request is issued.
- REQ: MemReq and MemAddr held stable until MemAck=1. At most one request is outstanding.
- REQ, MemAck=1, no Flush: push {MemAddr, MemRData} into FIFO tail, MemReq<=0, go to IDLE. Minimum turnaround is one address per 2 cycles. Zero-wait memory gives ProgAddr accepted at cycle N, Instr visible at cycle N+2.
- Flush=1 (priority over every other event except reset): FIFO cleared at next edge and any pop that cycle is ignored.
  - In REQ with MemAck=0: go to DISCARD.
  - In REQ with MemAck=1: data dropped, go to IDLE.
  - In IDLE: stay in IDLE, no accept.
  - In FAULT: remain in FAULT.
- DISCARD: MemReq stays high (requests cannot be aborted). On MemAck the data is dropped, MemReq<=0, go to IDLE. Flush in DISCARD keeps DISCARD.
- FAULT: terminal until reset. PCStall=1, MemReq=0. FIFO still drains to the decoder.
- FIFO: InstrValid = count!=0. Instr/InstrAddr come from the head register with no bubble. Pop on InstrValid && InstrReady. Push and pop in the same cycle keep count unchanged. Read/write pointers wrap modulo Depth.
- Overflow is impossible: a request is only issued when count<Depth, so a reserved slot exists at ack. A push into a full FIFO is a design error and the bench asserts it never occurs.
- Pop when empty is ignored.
- Address arithmetic is unsigned dataW bits. The block performs no address arithmetic itself; the PC owns increment and wrap.

Test Plan:
1. Zero-wait memory (MemAck same cycle as MemReq), InstrReady=1, ProgAddr 0,4,8 -> MemAddr 0,4,8 on alternating cycles; Instr/InstrAddr pairs (mem[0],0),(mem[4],4),(mem[8],8); each appears 2 cycles after its accept; PCStall high on every REQ cycle.
2. InstrReady=0, fetch from 0x10 -> after 2 entries (0x10,0x14) count=2, PCStall held 1, MemReq=0. Raise InstrReady one cycle -> one pop, InstrAddr=0x14, next accept on the following cycle.
3. MemAck delayed 3 cycles at MemAddr=0x20 -> MemReq and MemAddr=0x20 stable for 4 cycles; single push; no duplicate request.
4. Flush during REQ at 0x30 with MemAck delayed 2 more cycles, FIFO holding 1 entry -> FIFO empty next cycle; state DISCARD with MemReq high; ack data dropped (InstrValid stays 0); next accept takes new ProgAddr 0x100, whose Instr appears with InstrAddr=0x100.
5. Flush in the same cycle as MemAck and InstrReady -> response dropped, no pop counted, FIFO empty, IDLE next cycle.
6. ProgAddr=0x42 accepted -> FetchFault=1 next cycle and stays 1; MemReq never rises; PCStall=1 permanently; async reset mid-FAULT clears all outputs to reset values immediately.
